// File: rtl/turbo_pkg.sv
// Shared constants, state encoding and beat payload for the turbo encoder output stage.
package turbo_pkg;

   localparam int unsigned FRAME_BITS = 64;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned NUM_NIB    = FRAME_BITS / NIB_W;
   localparam int unsigned NUM_BEATS  = 3 * NUM_NIB;
   localparam int unsigned CYC_W      = $clog2(FRAME_BITS + NUM_NIB);
   localparam int unsigned BEAT_W     = $clog2(NUM_BEATS);
   localparam int unsigned IDX_W      = $clog2(NUM_NIB);
   localparam int unsigned SEL_W      = 2;

   typedef enum logic [1:0] {IDLE, FILL, CAPTURE, DRAIN} state_e;

   typedef enum logic [SEL_W-1:0] {SYS = 2'd0, P1 = 2'd1, P2 = 2'd2} stream_e;

   typedef struct packed {
      logic [NIB_W-1:0] data;
      stream_e          sel;
      logic             last;
   } beat_t;

endpackage

// File: rtl/turbo_c2b_sched_if.sv
// Nibble drain port from the frame scheduler to the symbol mapper.
interface turbo_c2b_sched_if;

   logic [turbo_pkg::NIB_W-1:0] out_data;
   logic [1:0]                  out_sel;
   logic                        out_valid;
   logic                        out_ready;
   logic                        out_last;

   modport master (output out_data, out_sel, out_valid, out_last, input out_ready);
   modport slave  (input out_data, out_sel, out_valid, out_last, output out_ready);

endinterface

// File: rtl/nib_buf.sv
// One packer stream's nibble store: synchronous write, asynchronous read, contents not reset.
module nib_buf
   import turbo_pkg::*;
(
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [NIB_W-1:0] wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [NIB_W-1:0] rd_data
);

   logic [NIB_W-1:0] mem_q [NUM_NIB];

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= wr_data;
   end

   assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/turbo_c2b_sched.sv
// Frame scheduler: enables the packers for one frame, captures their nibbles and
// drains them interleaved (sys, p1, p2 per index) over a valid/ready port.
module turbo_c2b_sched
   import turbo_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_req,
   input  logic             frame_abort,
   output logic             frame_ack,
   output logic             c2b_en,
   output logic             busy,
   input  logic [NIB_W-1:0] nib_sys,
   input  logic [NIB_W-1:0] nib_p1,
   input  logic [NIB_W-1:0] nib_p2,
   turbo_c2b_sched_if.master out_if
);

   state_e            state_q, state_d;
   logic [CYC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d, beat_nxt;
   logic              frame_ack_q, frame_ack_d;
   logic              c2b_en_q, c2b_en_d;
   logic              out_valid_q, out_valid_d;
   beat_t             out_q, out_d;
   logic              wr_en, fire, load_beat;
   logic [IDX_W-1:0]  wr_idx, rd_idx;
   stream_e           rd_sel;
   logic [NIB_W-1:0]  rd_sys, rd_p1, rd_p2, rd_data;

   assign fire   = out_valid_q & out_if.out_ready;
   assign wr_idx = IDX_W'(cyc_cnt_q - CYC_W'(FRAME_BITS));

   // Beat to present next: beat 0 on entry to DRAIN, otherwise the successor.
   assign beat_nxt = (state_q == CAPTURE) ? '0 : beat_cnt_q + BEAT_W'(1);
   assign rd_idx   = IDX_W'(beat_nxt / BEAT_W'(3));
   assign rd_sel   = stream_e'(SEL_W'(beat_nxt % BEAT_W'(3)));

   nib_buf u_buf_sys (.clk(clk), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(nib_sys),
                      .rd_idx(rd_idx), .rd_data(rd_sys));
   nib_buf u_buf_p1  (.clk(clk), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(nib_p1),
                      .rd_idx(rd_idx), .rd_data(rd_p1));
   nib_buf u_buf_p2  (.clk(clk), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(nib_p2),
                      .rd_idx(rd_idx), .rd_data(rd_p2));

   always_comb begin
      rd_data = rd_p2;
      case (rd_sel)
         SYS:     rd_data = rd_sys;
         P1:      rd_data = rd_p1;
         default: rd_data = rd_p2;
      endcase
   end

   // Next-state and output-register logic; abort overrides every state.
   always_comb begin
      state_d     = state_q;
      cyc_cnt_d   = cyc_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      frame_ack_d = 1'b0;
      c2b_en_d    = c2b_en_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;
      wr_en       = 1'b0;
      load_beat   = 1'b0;

      if (frame_abort) begin
         state_d     = IDLE;
         c2b_en_d    = 1'b0;
         out_valid_d = 1'b0;
         out_d       = '0;
         beat_cnt_d  = '0;
         cyc_cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (frame_req) begin
                  state_d     = FILL;
                  c2b_en_d    = 1'b1;
                  frame_ack_d = 1'b1;
                  cyc_cnt_d   = '0;
               end
            end
            FILL: begin
               cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
               if (cyc_cnt_q == CYC_W'(FRAME_BITS - 1)) state_d = CAPTURE;
            end
            CAPTURE: begin
               wr_en     = 1'b1;
               cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
               if (cyc_cnt_q == CYC_W'(FRAME_BITS + NUM_NIB - 1)) begin
                  state_d    = DRAIN;
                  c2b_en_d   = 1'b0;
                  beat_cnt_d = beat_nxt;
                  load_beat  = 1'b1;
               end
            end
            DRAIN: begin
               if (fire) begin
                  if (beat_cnt_q == BEAT_W'(NUM_BEATS - 1)) begin
                     state_d     = IDLE;
                     out_valid_d = 1'b0;
                     out_d       = '0;
                     beat_cnt_d  = '0;
                  end else begin
                     beat_cnt_d = beat_nxt;
                     load_beat  = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase

         if (load_beat) begin
            out_valid_d = 1'b1;
            out_d.data  = rd_data;
            out_d.sel   = rd_sel;
            out_d.last  = (beat_nxt == BEAT_W'(NUM_BEATS - 1));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cyc_cnt_q   <= '0;
         beat_cnt_q  <= '0;
         frame_ack_q <= 1'b0;
         c2b_en_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         cyc_cnt_q   <= cyc_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
         frame_ack_q <= frame_ack_d;
         c2b_en_q    <= c2b_en_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   assign frame_ack        = frame_ack_q;
   assign c2b_en           = c2b_en_q;
   assign busy             = (state_q != IDLE);
   assign out_if.out_valid = out_valid_q;
   assign out_if.out_data  = out_q.data;
   assign out_if.out_sel   = out_q.sel;
   assign out_if.out_last  = out_q.last;

endmodule

// File: tb/tb_turbo_c2b_sched.sv
// Self-checking bench for turbo_c2b_sched: control-vector table, directed frame
// scenarios and randomized frames checked against a frame-level model.
module tb_turbo_c2b_sched;
   import turbo_pkg::*;

   logic             clk;
   logic             rst_n;
   logic             frame_req;
   logic             frame_abort;
   logic             frame_ack;
   logic             c2b_en;
   logic             busy;
   logic [NIB_W-1:0] nib_sys, nib_p1, nib_p2;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int en_cnt = 0;
   int last_ack = 0;

   logic [NIB_W-1:0] pat_sys [NUM_NIB];
   logic [NIB_W-1:0] pat_p1  [NUM_NIB];
   logic [NIB_W-1:0] pat_p2  [NUM_NIB];

   turbo_c2b_sched_if sif ();

   turbo_c2b_sched dut (
      .clk(clk), .rst_n(rst_n), .frame_req(frame_req), .frame_abort(frame_abort),
      .frame_ack(frame_ack), .c2b_en(c2b_en), .busy(busy),
      .nib_sys(nib_sys), .nib_p1(nib_p1), .nib_p2(nib_p2), .out_if(sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Packer model: counts enabled edges; nibble i is valid after 64+i enabled edges.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)      en_cnt <= 0;
      else if (c2b_en) en_cnt <= en_cnt + 1;
      else             en_cnt <= 0;
   end

   always_comb begin
      if (en_cnt >= 64 && en_cnt < 80) begin
         nib_sys = pat_sys[4'(en_cnt - 64)];
         nib_p1  = pat_p1[4'(en_cnt - 64)];
         nib_p2  = pat_p2[4'(en_cnt - 64)];
      end else begin
         nib_sys = 4'hC;
         nib_p1  = 4'h3;
         nib_p2  = 4'h9;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dir_pattern();
      for (int i = 0; i < 16; i++) begin
         pat_sys[i] = 4'(i);
         pat_p1[i]  = ~4'(i);
         pat_p2[i]  = 4'(i) ^ 4'hA;
      end
   endtask

   task automatic set_rand_pattern();
      for (int i = 0; i < 16; i++) begin
         pat_sys[i] = 4'($urandom);
         pat_p1[i]  = 4'($urandom);
         pat_p2[i]  = 4'($urandom);
      end
   endtask

   // One frame: request, watch fill, collect the drain against the model.
   // rmode 0: ready always; 1: ready 1,0,0 repeating; 2: random. rst_beat>0 resets mid-drain.
   task automatic do_frame(input int rmode, input bit hold, input int rst_beat);
      logic [3:0] e_data [48];
      logic [1:0] e_sel  [48];
      logic [7:0] prev;
      int  n, en_cyc, ack_extra;
      bit  fin, stall_prev, rdy;
      for (int i = 0; i < 16; i++) begin
         e_data[3*i]   = pat_sys[i]; e_sel[3*i]   = 2'd0;
         e_data[3*i+1] = pat_p1[i];  e_sel[3*i+1] = 2'd1;
         e_data[3*i+2] = pat_p2[i];  e_sel[3*i+2] = 2'd2;
      end
      frame_req = 1'b1;
      tick();
      chk("frame_ack", 32'(frame_ack), 1);
      chk("start_en_busy", 32'({c2b_en, busy, sif.out_valid}), 3'b110);
      last_ack = cyc;
      frame_req = hold;
      n = 0; en_cyc = 1; ack_extra = 0; fin = 0; stall_prev = 0; prev = '0;
      for (int c = 0; c < 1000; c++) begin
         tick();
         if (fin) break;
         if (frame_ack) ack_extra++;
         if (c2b_en) en_cyc++;
         if (stall_prev)
            chk("stall_hold", 32'({sif.out_valid, sif.out_last, sif.out_sel, sif.out_data}), 32'(prev));
         if (!sif.out_valid)
            chk("idle_beat_zero", 32'({sif.out_last, sif.out_sel, sif.out_data}), 0);
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = (c % 3 == 0);
            default: rdy = ($urandom_range(0, 3) != 0);
         endcase
         sif.out_ready = rdy;
         if (sif.out_valid && rdy) begin
            chk($sformatf("beat%0d", n), 32'({sif.out_sel, sif.out_data, sif.out_last}),
                32'({e_sel[n], e_data[n], (n == 47)}));
            n++;
            if (n == 48) fin = 1'b1;
            if (n == rst_beat) begin
               #2 rst_n = 1'b0;
               #1;
               chk("async_rst_outputs", 32'({frame_ack, c2b_en, busy, sif.out_valid,
                   sif.out_last, sif.out_sel, sif.out_data}), 0);
               sif.out_ready = 1'b0;
               frame_req = 1'b0;
               @(negedge clk);
               @(negedge clk);
               rst_n = 1'b1;
               tick();
               chk("rst_release_idle", 32'({busy, c2b_en, sif.out_valid}), 0);
               return;
            end
         end
         stall_prev = sif.out_valid && !rdy;
         prev = {sif.out_valid, sif.out_last, sif.out_sel, sif.out_data};
      end
      chk("frame_done", 32'(fin), 1);
      chk("ack_single_pulse", ack_extra, 0);
      chk("c2b_en_cycles", en_cyc, 80);
      chk("end_idle", 32'({busy, c2b_en, sif.out_valid, sif.out_last, frame_ack}), 0);
      sif.out_ready = 1'b0;
   endtask

   typedef struct {
      logic req;
      logic abort;
      logic ack;
      logic en;
      logic bsy;
      logic vld;
   } vec_t;

   initial begin
      vec_t tbl [9];
      int   a1;
      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0; frame_req = 1'b0; frame_abort = 1'b0; sif.out_ready = 1'b0;
      set_dir_pattern();
      repeat (2) @(negedge clk);
      chk("reset_state", 32'({frame_ack, c2b_en, busy, sif.out_valid, sif.out_last,
          sif.out_sel, sif.out_data}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 9; i++) begin
         frame_req   = tbl[i].req;
         frame_abort = tbl[i].abort;
         tick();
         chk($sformatf("tbl%0d", i), 32'({frame_ack, c2b_en, busy, sif.out_valid}),
             32'({tbl[i].ack, tbl[i].en, tbl[i].bsy, tbl[i].vld}));
      end
      frame_req = 1'b0; frame_abort = 1'b0;
      tick();

      do_frame(0, 1'b0, -1);
      do_frame(1, 1'b0, -1);

      do_frame(0, 1'b1, -1);
      a1 = last_ack;
      do_frame(0, 1'b0, -1);
      chk("b2b_ack_spacing", last_ack - a1, 129);

      frame_req = 1'b1;
      tick();
      chk("abort_frame_ack", 32'(frame_ack), 1);
      frame_req = 1'b0;
      repeat (29) tick();
      chk("fill_cycle30", 32'({busy, c2b_en}), 3);
      frame_abort = 1'b1;
      tick();
      frame_abort = 1'b0;
      chk("abort_idle", 32'({busy, c2b_en, sif.out_valid}), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_stays_idle", 32'({busy, c2b_en, sif.out_valid}), 0);
      end
      do_frame(0, 1'b0, -1);

      do_frame(0, 1'b0, 20);
      do_frame(0, 1'b0, -1);

      for (int f = 0; f < 6; f++) begin
         frame_req = 1'b0;
         set_rand_pattern();
         repeat ($urandom_range(0, 3)) tick();
         do_frame(2, 1'($urandom_range(0, 1)), -1);
      end
      frame_req = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
